// File: rtl/sfr_pkg.sv
// Shared definitions for the special-function register writeback file:
// SREG bit positions, stack-pointer op encodings and default I/O addresses.
package sfr_pkg;

    localparam int unsigned SP_WIDTH = 16;

    // SREG bit positions (I T H S V N Z C, bit7..bit0)
    localparam int unsigned SREG_I = 7;
    localparam int unsigned SREG_T = 6;
    localparam int unsigned SREG_H = 5;
    localparam int unsigned SREG_S = 4;
    localparam int unsigned SREG_V = 3;
    localparam int unsigned SREG_N = 2;
    localparam int unsigned SREG_Z = 1;
    localparam int unsigned SREG_C = 0;

    // Stack pointer operation encodings
    typedef enum logic [1:0] {
        SP_NONE  = 2'b00,
        SP_PUSH  = 2'b01,
        SP_POP   = 2'b10,
        SP_NONE2 = 2'b11
    } sp_op_e;

    // Default reset value and I/O-space addresses
    localparam logic [15:0] SP_RESET_DEFAULT  = 16'h08FF;
    localparam logic [5:0]  SREG_ADDR_DEFAULT = 6'h3F;
    localparam logic [5:0]  SPH_ADDR_DEFAULT  = 6'h3E;
    localparam logic [5:0]  SPL_ADDR_DEFAULT  = 6'h3D;

endpackage

// File: rtl/sfr_sp_unit.sv
// Stack pointer register with push/pop arithmetic, byte-wise I/O writes,
// wrap detection and the sticky wrap fault.
module sfr_sp_unit
    import sfr_pkg::*;
#(
    parameter logic [15:0] SP_RESET = SP_RESET_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        spl_we,
    input  logic        sph_we,
    input  logic [7:0]  wdata,
    input  logic [1:0]  sp_op,
    input  logic [1:0]  sp_bytes,
    output logic [15:0] sp,
    output logic [15:0] sp_addr,
    output logic        sp_fault
);

    logic [15:0] r_sp;
    logic        r_fault;
    logic [15:0] w_n;
    logic [16:0] w_sum;
    logic [16:0] w_diff;
    logic [15:0] w_sp_next;
    logic        w_wrap;
    logic        w_fault_next;

    // Next SP, stack address and wrap flag; an I/O byte write overrides any op
    always_comb begin
        w_n          = (sp_bytes == 2'd0) ? 16'd1 : {14'd0, sp_bytes};
        w_sum        = {1'b0, r_sp} + {1'b0, w_n};
        w_diff       = {1'b0, r_sp} - {1'b0, w_n};
        w_sp_next    = r_sp;
        w_wrap       = 1'b0;
        sp_addr      = r_sp;
        w_fault_next = r_fault;
        case (sp_op)
            SP_PUSH: begin
                w_sp_next = w_diff[15:0];
                w_wrap    = w_diff[16];
                sp_addr   = r_sp;
            end
            SP_POP: begin
                w_sp_next = w_sum[15:0];
                w_wrap    = w_sum[16];
                sp_addr   = r_sp + 16'd1;
            end
            default: begin
                w_sp_next = r_sp;
                w_wrap    = 1'b0;
                sp_addr   = r_sp;
            end
        endcase
        if (spl_we || sph_we) begin
            w_sp_next    = {(sph_we ? wdata : r_sp[15:8]), (spl_we ? wdata : r_sp[7:0])};
            w_fault_next = 1'b0;
        end else begin
            w_fault_next = r_fault | w_wrap;
        end
    end

    // SP and fault state; hold while the pipeline is stalled
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sp    <= SP_RESET;
            r_fault <= 1'b0;
        end else if (stall) begin
            r_sp    <= r_sp;
            r_fault <= r_fault;
        end else begin
            r_sp    <= w_sp_next;
            r_fault <= w_fault_next;
        end
    end

    assign sp       = r_sp;
    assign sp_fault = r_fault;

endmodule

// File: rtl/sfr_writeback_file.sv
// Architectural SREG and stack pointer at the Execute/Writeback boundary.
// SREG merge (ALU flags, I/O writes, interrupt entry / RETI) lives here;
// SP handling is delegated to sfr_sp_unit.
module sfr_writeback_file
    import sfr_pkg::*;
#(
    parameter logic [15:0] SP_RESET  = SP_RESET_DEFAULT,
    parameter logic [5:0]  SREG_ADDR = SREG_ADDR_DEFAULT,
    parameter logic [5:0]  SPH_ADDR  = SPH_ADDR_DEFAULT,
    parameter logic [5:0]  SPL_ADDR  = SPL_ADDR_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic [7:0]  flag_we,
    input  logic [7:0]  flag_in,
    input  logic        io_we,
    input  logic [5:0]  io_waddr,
    input  logic [7:0]  io_wdata,
    input  logic [5:0]  io_raddr,
    output logic [7:0]  io_rdata,
    input  logic [1:0]  sp_op,
    input  logic [1:0]  sp_bytes,
    input  logic        irq_entry,
    input  logic        reti,
    output logic [7:0]  sreg,
    output logic [15:0] sp,
    output logic [15:0] sp_addr,
    output logic        sp_fault
);

    logic [7:0]  r_sreg;
    logic [7:0]  w_sreg_next;
    logic        w_spl_we;
    logic        w_sph_we;
    logic [15:0] w_sp;

    assign w_spl_we = io_we && (io_waddr == SPL_ADDR);
    assign w_sph_we = io_we && (io_waddr == SPH_ADDR);

    // SREG merge: I/O write lowest, ALU flags per enabled bit above it,
    // then RETI and finally interrupt entry on the I bit
    always_comb begin
        if (io_we && (io_waddr == SREG_ADDR)) begin
            w_sreg_next = io_wdata;
        end else begin
            w_sreg_next = r_sreg;
        end
        w_sreg_next = (w_sreg_next & ~flag_we) | (flag_in & flag_we);
        if (irq_entry) begin
            w_sreg_next[SREG_I] = 1'b0;
        end else if (reti) begin
            w_sreg_next[SREG_I] = 1'b1;
        end else begin
            w_sreg_next[SREG_I] = w_sreg_next[SREG_I];
        end
    end

    // SREG register; hold while stalled
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sreg <= 8'h00;
        end else if (stall) begin
            r_sreg <= r_sreg;
        end else begin
            r_sreg <= w_sreg_next;
        end
    end

    sfr_sp_unit #(
        .SP_RESET (SP_RESET)
    ) u_sp_unit (
        .clock    (clock),
        .reset    (reset),
        .stall    (stall),
        .spl_we   (w_spl_we),
        .sph_we   (w_sph_we),
        .wdata    (io_wdata),
        .sp_op    (sp_op),
        .sp_bytes (sp_bytes),
        .sp       (w_sp),
        .sp_addr  (sp_addr),
        .sp_fault (sp_fault)
    );

    // I/O read mux from current register state, zero for non-SFR addresses
    always_comb begin
        case (io_raddr)
            SREG_ADDR: io_rdata = r_sreg;
            SPH_ADDR:  io_rdata = w_sp[15:8];
            SPL_ADDR:  io_rdata = w_sp[7:0];
            default:   io_rdata = 8'h00;
        endcase
    end

    assign sreg = r_sreg;
    assign sp   = w_sp;

endmodule

// File: tb/tb_sfr_writeback_file.sv
// Directed self-checking bench for sfr_writeback_file.
module tb_sfr_writeback_file;

    logic        clock;
    logic        reset;
    logic        stall;
    logic [7:0]  flag_we;
    logic [7:0]  flag_in;
    logic        io_we;
    logic [5:0]  io_waddr;
    logic [7:0]  io_wdata;
    logic [5:0]  io_raddr;
    logic [7:0]  io_rdata;
    logic [1:0]  sp_op;
    logic [1:0]  sp_bytes;
    logic        irq_entry;
    logic        reti;
    logic [7:0]  sreg;
    logic [15:0] sp;
    logic [15:0] sp_addr;
    logic        sp_fault;

    int n_vec;
    int n_bad;

    sfr_writeback_file dut (
        .clock     (clock),
        .reset     (reset),
        .stall     (stall),
        .flag_we   (flag_we),
        .flag_in   (flag_in),
        .io_we     (io_we),
        .io_waddr  (io_waddr),
        .io_wdata  (io_wdata),
        .io_raddr  (io_raddr),
        .io_rdata  (io_rdata),
        .sp_op     (sp_op),
        .sp_bytes  (sp_bytes),
        .irq_entry (irq_entry),
        .reti      (reti),
        .sreg      (sreg),
        .sp        (sp),
        .sp_addr   (sp_addr),
        .sp_fault  (sp_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        stall     = 1'b0;
        flag_we   = 8'h00;
        flag_in   = 8'h00;
        io_we     = 1'b0;
        io_waddr  = 6'h00;
        io_wdata  = 8'h00;
        sp_op     = 2'b00;
        sp_bytes  = 2'd0;
        irq_entry = 1'b0;
        reti      = 1'b0;
    endtask

    // Apply the currently driven inputs for one rising edge, then return to idle
    task automatic tick();
        @(posedge clock);
        #1;
        idle_inputs();
        #1;
    endtask

    task automatic io_write(input logic [5:0] a, input logic [7:0] d);
        io_we = 1'b1; io_waddr = a; io_wdata = d;
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b0;
        io_raddr = 6'h3E;
        idle_inputs();
        #22;
        reset = 1'b1;
        @(posedge clock); #2;

        // Reset state
        check_val("rst_sreg",  {8'h00, sreg}, 16'h0000);
        check_val("rst_sp",    sp, 16'h08FF);
        check_val("rst_fault", {15'd0, sp_fault}, 16'h0000);
        check_val("rst_rd_sph", {8'h00, io_rdata}, 16'h0008);
        io_raddr = 6'h3D; #1;
        check_val("rst_rd_spl", {8'h00, io_rdata}, 16'h00FF);
        io_raddr = 6'h3C; #1;
        check_val("rd_unmapped", {8'h00, io_rdata}, 16'h0000);

        // Flag write merged with I/O write to SREG
        flag_we = 8'h03; flag_in = 8'hFF; io_we = 1'b1; io_waddr = 6'h3F; io_wdata = 8'hF0;
        #1;
        check_val("no_bypass", {8'h00, sreg}, 16'h0000);
        tick();
        check_val("merge_sreg", {8'h00, sreg}, 16'h00F3);
        io_raddr = 6'h3F; #1;
        check_val("rd_sreg", {8'h00, io_rdata}, 16'h00F3);

        // Push 2 / pop 2
        sp_op = 2'b01; sp_bytes = 2'd2; #1;
        check_val("push_addr", sp_addr, 16'h08FF);
        tick();
        check_val("push_sp", sp, 16'h08FD);
        sp_op = 2'b10; sp_bytes = 2'd2; #1;
        check_val("pop_addr", sp_addr, 16'h08FE);
        tick();
        check_val("pop_sp", sp, 16'h08FF);

        // sp_bytes=0 behaves as 1; op 11 is no-op
        sp_op = 2'b01; sp_bytes = 2'd0; tick();
        check_val("push0_sp", sp, 16'h08FE);
        sp_op = 2'b11; sp_bytes = 2'd3; #1;
        check_val("op11_addr", sp_addr, 16'h08FE);
        tick();
        check_val("op11_sp", sp, 16'h08FE);
        sp_op = 2'b10; sp_bytes = 2'd3; tick();
        check_val("pop3_sp", sp, 16'h0901);

        // Push wrap through zero
        io_write(6'h3D, 8'h01);
        io_write(6'h3E, 8'h00);
        check_val("io_sp", sp, 16'h0001);
        sp_op = 2'b01; sp_bytes = 2'd2; tick();
        check_val("wrap_push_sp", sp, 16'hFFFF);
        check_val("wrap_push_fault", {15'd0, sp_fault}, 16'h0001);
        sp_op = 2'b00; tick();
        check_val("fault_sticky", {15'd0, sp_fault}, 16'h0001);
        io_write(6'h3E, 8'h08);
        check_val("sph_sp", sp, 16'h08FF);
        check_val("sph_clr_fault", {15'd0, sp_fault}, 16'h0000);

        // Pop wrap, then I/O write beats a simultaneous push
        io_write(6'h3E, 8'hFF);
        sp_op = 2'b10; sp_bytes = 2'd1; tick();
        check_val("wrap_pop_sp", sp, 16'h0000);
        check_val("wrap_pop_fault", {15'd0, sp_fault}, 16'h0001);
        sp_op = 2'b01; sp_bytes = 2'd1; io_we = 1'b1; io_waddr = 6'h3D; io_wdata = 8'hFF;
        tick();
        check_val("io_wins_sp", sp, 16'h00FF);
        check_val("io_wins_fault", {15'd0, sp_fault}, 16'h0000);

        // Interrupt entry / RETI on I
        irq_entry = 1'b1; reti = 1'b1; tick();
        check_val("irq_reti", {8'h00, sreg}, 16'h0073);
        reti = 1'b1; tick();
        check_val("reti", {8'h00, sreg}, 16'h00F3);
        irq_entry = 1'b1; flag_we = 8'h80; flag_in = 8'h80; tick();
        check_val("irq_over_flag", {8'h00, sreg}, 16'h0073);

        // Stall holds everything, sp_addr still live
        stall = 1'b1; sp_op = 2'b01; sp_bytes = 2'd1; flag_we = 8'hFF; flag_in = 8'h00; #1;
        check_val("stall_addr", sp_addr, 16'h00FF);
        tick();
        check_val("stall_sreg", {8'h00, sreg}, 16'h0073);
        check_val("stall_sp", sp, 16'h00FF);
        tick();
        check_val("rel_sreg", {8'h00, sreg}, 16'h0073);
        check_val("rel_sp", sp, 16'h00FF);

        // Reset pulse during a push
        sp_op = 2'b01; sp_bytes = 2'd2; #1;
        reset = 1'b0; #1;
        check_val("arst_sp", sp, 16'h08FF);
        check_val("arst_sreg", {8'h00, sreg}, 16'h0000);
        @(negedge clock);
        reset = 1'b1;
        idle_inputs();
        tick();
        check_val("post_rst_sp", sp, 16'h08FF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
